// File: rtl/flag_sequencer.sv
// Flag slideshow sequencer: steps through NUM_FLAGS colour channels, either on
// next/prev requests or on a frame-count timer, with a left-to-right wipe
// between the outgoing and incoming flag. The pixel colour is registered.
module flag_sequencer #(
  parameter int NUM_FLAGS    = 45,
  parameter int COLOR_W      = 6,
  parameter int DWELL_FRAMES = 180,
  parameter int WIPE_STEP    = 16,
  parameter int SCREEN_W     = 640
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          frame_start,
  input  logic                          next,
  input  logic                          prev,
  input  logic                          auto_en,
  input  logic [9:0]                    pix_x,
  input  logic [9:0]                    pix_y,
  input  logic [NUM_FLAGS*COLOR_W-1:0]  flag_colors,
  output logic [COLOR_W-1:0]            color,
  output logic [7:0]                    selector,
  output logic [7:0]                    count,
  output logic                          busy
);

  // state | meaning
  // IDLE  | showing cur_sel, dwell timer running when auto_en
  // WIPE  | edge at wipe_pos: cur_sel left of it, old_sel right of it

  if (NUM_FLAGS < 2 || NUM_FLAGS > 256) begin : g_bad_num_flags
    $error("flag_sequencer: NUM_FLAGS must be 2..256");
  end
  if (DWELL_FRAMES < 1) begin : g_bad_dwell
    $error("flag_sequencer: DWELL_FRAMES must be >= 1");
  end
  if (WIPE_STEP < 1) begin : g_bad_step
    $error("flag_sequencer: WIPE_STEP must be >= 1");
  end

  typedef enum logic {IDLE, WIPE} state_t;
  typedef enum logic [1:0] {REQ_NONE, REQ_NEXT, REQ_PREV} req_t;

  localparam int              DW_W       = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [7:0]      SEL_LAST   = 8'(NUM_FLAGS - 1);

  state_t            state, state_next;
  req_t              req;
  logic [7:0]        cur_sel, old_sel;
  logic [DW_W-1:0]   dwell_cnt;
  logic [10:0]       wipe_pos;
  logic [11:0]       wipe_sum;
  logic [7:0]        sel_inc, sel_dec, chan_sel;
  logic              start, go_prev, wipe_done;
  logic [COLOR_W-1:0] color_d;
  logic              unused_pix_y;

  // Row only matters for raster alignment upstream; nothing here depends on it.
  assign unused_pix_y = ^pix_y;

  // Full 256-entry channel table so an 8-bit index can never fall off the end;
  // entries beyond NUM_FLAGS are unreachable and tied to zero.
  logic [COLOR_W-1:0] chans [256];
  for (genvar g = 0; g < 256; g++) begin : g_chan
    if (g < NUM_FLAGS) begin : g_used
      assign chans[g] = flag_colors[g*COLOR_W +: COLOR_W];
    end else begin : g_pad
      assign chans[g] = '0;
    end
  end

  // Transition triggers and wrap-around neighbours of the current flag.
  always_comb begin
    sel_inc   = (cur_sel == SEL_LAST) ? 8'd0 : cur_sel + 8'd1;
    sel_dec   = (cur_sel == 8'd0) ? SEL_LAST : cur_sel - 8'd1;
    wipe_sum  = {1'b0, wipe_pos} + 12'(WIPE_STEP);
    go_prev   = (req == REQ_PREV);
    start     = (state == IDLE) && frame_start &&
                ((req != REQ_NONE) || (auto_en && (dwell_cnt == DWELL_LAST)));
    wipe_done = (state == WIPE) && frame_start && (wipe_sum >= 12'(SCREEN_W));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = WIPE;
      WIPE:    if (wipe_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: status outputs and the unregistered pixel choice.
  always_comb begin
    busy     = (state == WIPE);
    selector = cur_sel;
    count    = 8'(NUM_FLAGS);
    chan_sel = ((state == WIPE) && ({1'b0, pix_x} >= wipe_pos)) ? old_sel : cur_sel;
    color_d  = chans[chan_sel];
  end

  // Datapath: request latch, flag indices, dwell timer and wipe edge.
  // A pulse arriving in the cycle a transition starts wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      req       <= REQ_NONE;
      cur_sel   <= 8'd0;
      old_sel   <= 8'd0;
      dwell_cnt <= '0;
      wipe_pos  <= '0;
    end else begin
      if (next || prev)
        req <= (next && prev) ? REQ_NONE : (next ? REQ_NEXT : REQ_PREV);
      else if (start)
        req <= REQ_NONE;

      if (start) begin
        old_sel  <= cur_sel;
        cur_sel  <= go_prev ? sel_dec : sel_inc;
        wipe_pos <= '0;
      end else if ((state == WIPE) && frame_start) begin
        wipe_pos <= wipe_done ? 11'd0 : wipe_sum[10:0];
      end

      if (!auto_en || start)
        dwell_cnt <= '0;
      else if ((state == IDLE) && frame_start)
        dwell_cnt <= dwell_cnt + DW_W'(1);
    end
  end

  // Registered pixel colour, one cycle behind pix_x.
  always_ff @(posedge clk) begin
    if (rst) color <= '0;
    else     color <= color_d;
  end

endmodule

// File: tb/tb_flag_sequencer.sv
// Bench for flag_sequencer: directed vector table for the documented
// scenarios, then randomized traffic against a frame-level reference model.
module tb_flag_sequencer;

  localparam int N      = 4;
  localparam int CW     = 6;
  localparam int DWELL  = 3;
  localparam int STEP   = 320;
  localparam int SCREEN = 640;

  logic            clk = 1'b0;
  logic            rst, frame_start, next, prev, auto_en;
  logic [9:0]      pix_x, pix_y;
  logic [N*CW-1:0] flag_colors;
  logic [CW-1:0]   color;
  logic [7:0]      selector, count;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  flag_sequencer #(
    .NUM_FLAGS(N), .COLOR_W(CW), .DWELL_FRAMES(DWELL),
    .WIPE_STEP(STEP), .SCREEN_W(SCREEN)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .next(next), .prev(prev),
    .auto_en(auto_en), .pix_x(pix_x), .pix_y(pix_y), .flag_colors(flag_colors),
    .color(color), .selector(selector), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, fs, nx, pv, ae;
    int   px;
    int   sel, bsy, col;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic fs, input logic nx, input logic pv,
                     input logic ae, input int px, input int sel, input int bsy, input int col);
    vec_t v;
    v.rst = r; v.fs = fs; v.nx = nx; v.pv = pv; v.ae = ae; v.px = px;
    v.sel = sel; v.bsy = bsy; v.col = col;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic fs, input logic nx, input logic pv,
                       input logic ae, input int px);
    rst = r; frame_start = fs; next = nx; prev = pv; auto_en = ae;
    pix_x = 10'(px); pix_y = 10'($urandom_range(0, 479));
  endtask

  // Reference model: flag index, outgoing flag, wipe progress in frames,
  // frames dwelt, and pending request as -1/0/+1.
  int m_sel, m_old, m_busy, m_wf, m_dwell, m_req, m_color;

  task automatic model_step(input logic r, input logic fs, input logic nx, input logic pv,
                            input logic ae, input int px);
    int new_req, dir;
    if (r) begin
      m_sel = 0; m_old = 0; m_busy = 0; m_wf = 0; m_dwell = 0; m_req = 0; m_color = 0;
      return;
    end
    if (m_busy != 0 && px >= m_wf * STEP) m_color = m_old + 1;
    else                                  m_color = m_sel + 1;
    new_req = m_req;
    if (m_busy == 0) begin
      if (fs && (m_req != 0 || (ae && m_dwell == DWELL - 1))) begin
        dir     = (m_req == -1) ? -1 : 1;
        m_old   = m_sel;
        m_sel   = (m_sel + dir + N) % N;
        m_dwell = 0;
        m_busy  = 1;
        m_wf    = 0;
        new_req = 0;
      end else if (fs && ae) begin
        m_dwell++;
      end
    end else if (fs) begin
      m_wf++;
      if (m_wf * STEP >= SCREEN) begin
        m_busy = 0;
        m_wf   = 0;
      end
    end
    if (!ae) m_dwell = 0;
    if (nx || pv) new_req = (nx && pv) ? 0 : (nx ? 1 : -1);
    m_req = new_req;
  endtask

  initial begin
    logic ae_r;
    for (int i = 0; i < N; i++) flag_colors[i*CW +: CW] = CW'(i + 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    //   rst fs nx pv ae  px   sel busy col
    add(1, 0, 0, 0, 0,   0,   0, 0, 0);
    add(0, 0, 0, 0, 1,   0,   0, 0, 1);
    add(0, 1, 0, 0, 1,   0,   0, 0, 1);
    add(0, 0, 0, 0, 1,   0,   0, 0, 1);
    add(0, 1, 0, 0, 1,   0,   0, 0, 1);
    add(0, 1, 0, 0, 1,   0,   1, 1, 1);   // third frame: auto advance
    add(0, 0, 0, 0, 1, 100,   1, 1, 1);
    add(0, 1, 0, 0, 1,   0,   1, 1, 1);
    add(0, 0, 0, 0, 1, 100,   1, 1, 2);
    add(0, 0, 0, 0, 1, 500,   1, 1, 1);
    add(0, 1, 0, 0, 1,   0,   1, 0, 2);   // wipe over after 2 frames
    add(0, 0, 1, 0, 0,   0,   1, 0, 2);
    add(0, 1, 0, 0, 0,   0,   2, 1, 2);
    add(0, 1, 0, 0, 0,   0,   2, 1, 2);
    add(0, 1, 0, 0, 0,   0,   2, 0, 3);
    add(0, 0, 1, 0, 0,   0,   2, 0, 3);
    add(0, 1, 0, 0, 0,   0,   3, 1, 3);
    add(0, 1, 0, 0, 0,   0,   3, 1, 3);
    add(0, 1, 0, 0, 0,   0,   3, 0, 4);
    add(0, 0, 1, 0, 0,   0,   3, 0, 4);   // next from last flag wraps
    add(0, 1, 0, 0, 0,   0,   0, 1, 4);
    add(0, 1, 0, 0, 0,   0,   0, 1, 4);
    add(0, 0, 0, 0, 0, 100,   0, 1, 1);
    add(0, 0, 0, 0, 0, 500,   0, 1, 4);
    add(0, 1, 0, 0, 0,   0,   0, 0, 1);
    add(0, 0, 0, 1, 0,   0,   0, 0, 1);   // prev from flag 0 wraps
    add(0, 1, 0, 0, 0,   0,   3, 1, 1);
    add(0, 1, 0, 0, 0,   0,   3, 1, 1);
    add(0, 1, 0, 0, 0,   0,   3, 0, 4);
    add(0, 0, 1, 1, 0,   0,   3, 0, 4);   // simultaneous next+prev cancels
    add(0, 1, 0, 0, 0,   0,   3, 0, 4);
    add(0, 0, 1, 0, 0,   0,   3, 0, 4);
    add(0, 1, 0, 0, 0,   0,   0, 1, 4);
    add(0, 0, 1, 0, 0,   0,   0, 1, 4);   // next held during wipe
    add(0, 1, 0, 0, 0,   0,   0, 1, 4);
    add(0, 1, 0, 0, 0,   0,   0, 0, 1);
    add(0, 1, 0, 0, 0,   0,   1, 1, 1);   // held request serviced
    add(0, 1, 0, 0, 0,   0,   1, 1, 1);
    add(1, 1, 0, 0, 0,   0,   0, 0, 0);   // reset mid-wipe
    add(0, 1, 0, 0, 0,   0,   0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].fs, vecs[i].nx, vecs[i].pv, vecs[i].ae, vecs[i].px);
      @(posedge clk); #1;
      check("vec_selector", i, int'(selector), vecs[i].sel);
      check("vec_busy",     i, int'(busy),     vecs[i].bsy);
      check("vec_color",    i, int'(color),    vecs[i].col);
      check("vec_count",    i, int'(count),    N);
    end

    ae_r = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 4000; c++) begin
      logic r, fs, nx, pv;
      int   px;
      r  = ($urandom_range(0, 399) == 0);
      fs = ($urandom_range(0, 5) == 0);
      nx = ($urandom_range(0, 15) == 0);
      pv = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) ae_r = ~ae_r;
      px = $urandom_range(0, SCREEN - 1);
      model_step(r, fs, nx, pv, ae_r, px);
      drive(r, fs, nx, pv, ae_r, px);
      @(posedge clk); #1;
      check("rnd_selector", c, int'(selector), m_sel);
      check("rnd_busy",     c, int'(busy),     m_busy);
      check("rnd_color",    c, int'(color),    m_color);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_sequencer.md
FLAG_SEQUENCER -- requirements
Module: flag_sequencer

Interface
REQ-001 Parameter NUM_FLAGS, default 45, number of flag colour channels; SHALL be 2..256.
REQ-002 Parameter COLOR_W, default 6, bits per colour channel (RRGGBB).
REQ-003 Parameter DWELL_FRAMES, default 180, frames per flag in auto mode; SHALL be ≥1.
REQ-004 Parameter WIPE_STEP, default 16, pixels the wipe edge advances per frame; SHALL be ≥1.
REQ-005 Parameter SCREEN_W, default 640, visible width in pixels.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 frame_start  in  1  one-cycle pulse at start of each frame.
REQ-009 next  in  1  one-cycle request to advance to the following flag.
REQ-010 prev  in  1  one-cycle request to step back to the preceding flag.
REQ-011 auto_en  in  1  level; enables timed auto-advance.
REQ-012 pix_x  in  10  current pixel column.
REQ-013 pix_y  in  10  current pixel row; passed to no logic other than the output pipeline alignment.
REQ-014 flag_colors  in  NUM_FLAGS*COLOR_W  flat bus; channel i at bits [i*COLOR_W +: COLOR_W].
REQ-015 color  out  COLOR_W  registered pixel colour.
REQ-016 selector  out  8  index of current (target) flag.
REQ-017 count  out  8  constant NUM_FLAGS.
REQ-018 busy  out  1  high while a wipe transition is in progress.

Function
REQ-019 FSM states SHALL be IDLE and WIPE; registers: cur_sel, old_sel, dwell_cnt, wipe_pos (11 bits), req (NONE/NEXT/PREV).
REQ-020 next or prev pulse SHALL be latched into req in any state; a later pulse overwrites an earlier one; next and prev in the same cycle SHALL set req=NONE.
REQ-021 In IDLE with auto_en=1, dwell_cnt SHALL increment on each frame_start; with auto_en=0 dwell_cnt SHALL be held at 0.
REQ-022 A transition SHALL start only on a frame_start in IDLE, when req≠NONE or (auto_en=1 and dwell_cnt=DWELL_FRAMES-1).
REQ-023 req=PREV SHALL take priority over auto expiry; req=NEXT plus expiry in the same frame SHALL advance exactly once.
REQ-024 Start of transition: old_sel←cur_sel; cur_sel←cur_sel±1 modulo NUM_FLAGS (NUM_FLAGS-1→0 on next; 0→NUM_FLAGS-1 on prev); dwell_cnt←0; req←NONE; wipe_pos←0; state←WIPE.
REQ-025 In WIPE, each frame_start SHALL add WIPE_STEP to wipe_pos; when the sum ≥SCREEN_W state SHALL return to IDLE and wipe_pos←0.
REQ-026 Requests latched during WIPE SHALL be held and serviced at the first frame_start after return to IDLE; dwell_cnt SHALL stay frozen in WIPE.
REQ-027 Pixel select: IDLE → channel cur_sel; WIPE → channel cur_sel if pix_x < wipe_pos, else channel old_sel.
REQ-028 color SHALL be registered: value for pix_x/state sampled at edge N appears after edge N (latency 1 cycle).
REQ-029 selector SHALL equal cur_sel combinationally from the register; busy SHALL equal (state==WIPE).
REQ-030 All arithmetic on cur_sel SHALL be explicit modulo NUM_FLAGS; no out-of-range index SHALL ever be selected.

Reset
REQ-031 rst=1 at an edge SHALL force cur_sel=0, old_sel=0, dwell_cnt=0, wipe_pos=0, req=NONE, state=IDLE, color=0, busy=0, overriding all other inputs including mid-wipe.
REQ-032 First frame_start after rst deasserts SHALL be treated as a normal frame.

Verification (NUM_FLAGS=4, DWELL_FRAMES=3, WIPE_STEP=320, SCREEN_W=640, channel i colour = i+1)
REQ-033 Reset then auto_en=1, 3 frame_starts -> selector 0→1 on 3rd, busy=1 for 2 frames, then 0; dwell restarts.
REQ-034 selector=3, next pulse, frame_start -> selector=0, old flag 3; mid-wipe pix_x=100 gives color=1, pix_x=500 gives color=4 one cycle later.
REQ-035 selector=0, prev pulse, frame_start -> selector=3; next and prev in same cycle -> no transition at frame_start.
REQ-036 next pulse during WIPE -> no change until wipe ends; at following frame_start selector advances once more.
REQ-037 rst asserted mid-wipe -> next cycle selector=0, busy=0, color=0; count reads 4 throughout.
